// File: rtl/instr_enc.sv
// RV32 instruction encoder: packs decoded fields into instruction words, range-checks
// immediates and expands LI into LUI+ADDI, with valid/ready handshakes on both sides.
module instr_enc (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] count_instr
);
    localparam logic [6:0]  OP_IMM = 7'b0010011;
    localparam logic [6:0]  OP_LUI = 7'b0110111;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {EMPTY, FULL, FULL_LI} state_t;

    state_t      state_q, state_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] pend_q, pend_d;
    logic        out_err_q, out_err_d;
    logic [15:0] count_q, count_d;

    logic        in_hs, out_hs;
    logic        fits12, fits13, fits21;
    logic [11:0] lo;
    logic [19:0] hi;
    logic [31:0] new_word, li_addi;
    logic        new_err, new_two;

    assign out_valid   = (state_q != EMPTY);
    assign in_ready    = (state_q == EMPTY) | ((state_q == FULL) & out_ready);
    assign in_hs       = in_valid & in_ready;
    assign out_hs      = out_valid & out_ready;
    assign out_instr   = out_instr_q;
    assign out_err     = out_err_q;
    assign count_instr = count_q;

    // An immediate fits an N-bit signed field when all bits above N-1 match the sign bit.
    assign fits12 = (in_imm[31:11] == '0) | (in_imm[31:11] == '1);
    assign fits13 = (in_imm[31:12] == '0) | (in_imm[31:12] == '1);
    assign fits21 = (in_imm[31:20] == '0) | (in_imm[31:20] == '1);
    assign lo     = in_imm[11:0];
    // ADDI sign-extends lo, so the upper part must absorb the borrow from bit 11.
    assign hi     = in_imm[31:12] + {19'd0, in_imm[11]};

    always_comb begin
        new_word = NOP;
        new_err  = 1'b0;
        new_two  = 1'b0;
        li_addi  = {lo, in_rd, 3'b000, in_rd, OP_IMM};
        case (in_fmt)
            3'd0: new_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: begin
                new_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                new_err  = ~fits12;
            end
            3'd2: begin
                new_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                new_err  = ~fits12;
            end
            3'd3: begin
                new_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                new_err  = ~fits13 | in_imm[0];
            end
            3'd4: begin
                new_word = {in_imm[31:12], in_rd, in_opcode};
                new_err  = (in_imm[11:0] != 12'd0);
            end
            3'd5: begin
                new_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                new_err  = ~fits21 | in_imm[0];
            end
            3'd6: begin
                if (fits12) begin
                    new_word = {lo, 5'd0, 3'b000, in_rd, OP_IMM};
                end else begin
                    new_word = {hi, in_rd, OP_LUI};
                    new_two  = (lo != 12'd0);
                end
            end
            default: new_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_instr_d = out_instr_q;
        out_err_d   = out_err_q;
        pend_d      = pend_q;
        count_d     = out_hs ? count_q + 16'd1 : count_q;
        case (state_q)
            FULL_LI: begin
                if (out_hs) begin
                    out_instr_d = pend_q;
                    out_err_d   = 1'b0;
                    state_d     = FULL;
                end
            end
            default: begin
                if (in_hs) begin
                    out_instr_d = new_word;
                    out_err_d   = new_err;
                    pend_d      = li_addi;
                    state_d     = new_two ? FULL_LI : FULL;
                end else if (out_hs) begin
                    state_d = EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_instr_q <= 32'd0;
            out_err_q   <= 1'b0;
            pend_q      <= 32'd0;
            count_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            out_instr_q <= out_instr_d;
            out_err_q   <= out_err_d;
            pend_q      <= pend_d;
            count_q     <= count_d;
        end
    end
endmodule

// File: doc/instr_enc.md
# instr_enc

Instruction encoder: the inverse of the decode-stage immediate extractor. It accepts decoded fields (format, opcode, registers, functs, full 32-bit immediate) over a valid/ready handshake and emits packed RV32 instruction words over a second valid/ready handshake. It range-checks immediates and expands the LI pseudo-op into LUI+ADDI. It sits between the boot/test program generator and instruction memory write port.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder accepts input this cycle
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=LI, 7=illegal
- in_opcode  in  7  opcode[6:0]; ignored for LI
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R only)
- in_imm  in  32  full signed immediate value (byte offset for B/J; full value for U)
- out_valid  out  1  out_instr valid
- out_ready  in  1  consumer accepts out_instr
- out_instr  out  32  encoded instruction
- out_err  out  1  immediate out of range / misaligned / illegal format; qualifies out_instr
- count_instr  out  16  number of completed output handshakes, wraps 0xFFFF->0

## Operation
- Packing: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Range checks (fail -> out_err=1, word still packed from truncated bits): I/S imm in [-2048,2047]; B imm in [-4096,4094] and imm[0]=0; J imm in [-2^20,2^20-2] and imm[0]=0; U imm[11:0]=0; R never errs.
- Illegal fmt (7): out_instr=32'h0000_0013 (NOP), out_err=1.
- LI: lo=imm[11:0], hi=imm[31:12]+imm[11] (mod 2^20).
  - imm in [-2048,2047]: one word ADDI rd,x0,lo (op 0010011, f3 000).
  - else lo==0: one word LUI rd,hi (op 0110111).
  - else two words: LUI rd,hi then ADDI rd,rd,lo. LI never errs.
- FSM states: EMPTY (no output held), FULL (one word held), FULL_LI (LUI held, ADDI pending internally).
  - EMPTY: in handshake -> FULL, or FULL_LI if LI needs two words.
  - FULL: out handshake with no new input -> EMPTY; out handshake with simultaneous input handshake -> load new word (FULL or FULL_LI).
  - FULL_LI: out handshake -> FULL holding ADDI; in_ready=0 throughout.
- in_ready = (state==EMPTY) | (state==FULL & out_ready).
- count_instr increments on each out_valid&out_ready; LI two-word expansion counts 2.

## Timing
- Reset: out_valid=0, out_instr=0, out_err=0, count_instr=0, state EMPTY, in_ready=1 the cycle after reset deasserts.
- Latency: input accepted at cycle N -> out_valid at N+1.
- Throughput: 1 word/cycle with out_ready held high; two-word LI consumes 2 output cycles, input blocked on the second.
- out_instr/out_err stable while out_valid=1 and out_ready=0.
- Reset during FULL_LI discards held LUI and pending ADDI; nothing emitted after.
- in_* sampled only on in_valid&in_ready; fields ignored otherwise.

## Test plan
- I: fmt=1, op=0010011, rd=1, rs1=2, f3=0, imm=0xFFFF_FFFF -> next cycle out_instr=0xFFF10093, out_err=0, count_instr=1 after handshake.
- S: fmt=2, op=0100011, f3=010, rs1=10, rs2=5, imm=8 -> 0x00552423; J: fmt=5, op=1101111, rd=1, imm=0x800 -> 0x001000EF.
- Errors: fmt=3 imm=3 -> out_err=1; fmt=1 imm=2048 -> out_err=1; fmt=7 -> out_instr=0x00000013, out_err=1.
- LI: fmt=6, rd=5, imm=0x12345FFF -> 0x123462B7 then 0xFFF28293, in_ready=0 between, count +2; imm=-5 -> single 0xFFB00293.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_instr stable; releasing gives back-to-back words, none lost or duplicated.
- Reset asserted while LUI of LI held -> out_valid=0, count_instr=0 next cycle, no ADDI emitted afterward.
